// File: rtl/mdu_pkg.sv
// Shared types for the iterative multiply/divide unit: RISC-V M-extension
// funct3 operation codes and the controller state encoding.
package mdu_pkg;

  typedef enum logic [2:0] {
    MDU_MUL    = 3'd0,
    MDU_MULH   = 3'd1,
    MDU_MULHSU = 3'd2,
    MDU_MULHU  = 3'd3,
    MDU_DIV    = 3'd4,
    MDU_DIVU   = 3'd5,
    MDU_REM    = 3'd6,
    MDU_REMU   = 3'd7
  } mdu_op_e;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    MUL  = 3'd1,
    DIV  = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } mdu_state_e;

  // funct3 bit 2 selects divide/remainder; bit 1 selects remainder; bit 0 unsigned.
  function automatic logic op_is_div(input mdu_op_e op);
    return op[2];
  endfunction

  function automatic logic op_is_rem(input mdu_op_e op);
    return op[1];
  endfunction

  function automatic logic op_div_signed(input mdu_op_e op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/mdu_div_step.sv
// One restoring radix-2 division step: shift in the next dividend bit and
// subtract the divisor when it fits.
module mdu_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic [WIDTH-1:0] i_divisor,
  input  logic             i_bit,
  output logic [WIDTH-1:0] o_rem,
  output logic             o_q
);

  logic [WIDTH:0] w_shift;
  logic [WIDTH:0] w_diff;

  // Partial remainder is always below the divisor, so the shifted value is
  // below twice the divisor and the borrow bit of the difference is exact.
  assign w_shift = {i_rem, i_bit};
  assign w_diff  = w_shift - {1'b0, i_divisor};
  assign o_q     = ~w_diff[WIDTH];
  assign o_rem   = o_q ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];

endmodule

// File: rtl/mdu_iter.sv
// Iterative RV32M multiply/divide unit: 2-cycle multiply, WIDTH-iteration
// restoring divide, valid/ready request and response channels with flush.
module mdu_iter
  import mdu_pkg::*;
#(
  parameter  int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             kill_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [WIDTH-1:0] result_o,
  output logic             busy_o
);

  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  mdu_state_e       r_state, w_state_nxt;
  mdu_op_e          r_op, w_op_in;
  logic [WIDTH-1:0] r_a, r_b, r_rem, r_result;
  logic [CNT_W-1:0] r_cnt;
  logic             r_neg_q, r_neg_r;

  logic             w_accept, w_in_div, w_in_rem, w_in_signed;
  logic             w_sa, w_sb, w_b_zero, w_ovf, w_special;
  logic [WIDTH-1:0] w_abs_a, w_abs_b, w_special_res;

  assign w_op_in     = mdu_op_e'(op_i);
  assign w_accept    = req_valid_i && (r_state == IDLE) && !kill_i;
  assign w_in_div    = op_is_div(w_op_in);
  assign w_in_rem    = op_is_rem(w_op_in);
  assign w_in_signed = op_div_signed(w_op_in);

  // Divide special cases are resolved straight from the request operands.
  assign w_sa          = w_in_signed & a_i[WIDTH-1];
  assign w_sb          = w_in_signed & b_i[WIDTH-1];
  assign w_abs_a       = w_sa ? -a_i : a_i;
  assign w_abs_b       = w_sb ? -b_i : b_i;
  assign w_b_zero      = (b_i == '0);
  assign w_ovf         = w_in_signed && (a_i == MOST_NEG) && (b_i == '1);
  assign w_special     = w_b_zero || w_ovf;
  assign w_special_res = w_b_zero ? (w_in_rem ? a_i : '1)
                                  : (w_in_rem ? '0  : a_i);

  // Multiply: extending to 2*WIDTH bits gives the exact low half of the
  // (WIDTH+1)x(WIDTH+1) signed product, which is all that is ever selected.
  logic                 w_mul_sa, w_mul_sb;
  logic [2*WIDTH-1:0]   w_a_ext, w_b_ext, w_prod;
  logic [WIDTH-1:0]     w_mul_res;

  assign w_mul_sa  = ((r_op == MDU_MULH) || (r_op == MDU_MULHSU)) && r_a[WIDTH-1];
  assign w_mul_sb  = (r_op == MDU_MULH) && r_b[WIDTH-1];
  assign w_a_ext   = {{WIDTH{w_mul_sa}}, r_a};
  assign w_b_ext   = {{WIDTH{w_mul_sb}}, r_b};
  assign w_prod    = w_a_ext * w_b_ext;
  assign w_mul_res = (r_op == MDU_MUL) ? w_prod[WIDTH-1:0] : w_prod[2*WIDTH-1:WIDTH];

  logic [WIDTH-1:0] w_step_rem, w_quo_fix, w_rem_fix, w_fix_res;
  logic             w_step_q;

  mdu_div_step #(
    .WIDTH(WIDTH)
  ) u_div_step (
    .i_rem    (r_rem),
    .i_divisor(r_b),
    .i_bit    (r_a[WIDTH-1]),
    .o_rem    (w_step_rem),
    .o_q      (w_step_q)
  );

  assign w_quo_fix = r_neg_q ? -r_a : r_a;
  assign w_rem_fix = r_neg_r ? -r_rem : r_rem;
  assign w_fix_res = op_is_rem(r_op) ? w_rem_fix : w_quo_fix;

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (!w_in_div)      w_state_nxt = MUL;
          else if (w_special) w_state_nxt = DONE;
          else                w_state_nxt = DIV;
        end
      end
      MUL:  w_state_nxt = kill_i ? IDLE : DONE;
      DIV: begin
        if (kill_i)                      w_state_nxt = IDLE;
        else if (r_cnt == CNT_W'(1))     w_state_nxt = FIX;
      end
      FIX:  w_state_nxt = kill_i ? IDLE : DONE;
      DONE: if (kill_i || rsp_ready_i) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // The dividend register doubles as the quotient shift register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_op     <= MDU_MUL;
      r_a      <= '0;
      r_b      <= '0;
      r_rem    <= '0;
      r_cnt    <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_result <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_op <= w_op_in;
            if (w_in_div) begin
              r_a     <= w_abs_a;
              r_b     <= w_abs_b;
              r_rem   <= '0;
              r_cnt   <= CNT_W'(WIDTH);
              r_neg_q <= w_sa ^ w_sb;
              r_neg_r <= w_sa;
              if (w_special) r_result <= w_special_res;
            end else begin
              r_a <= a_i;
              r_b <= b_i;
            end
          end
        end
        MUL: if (!kill_i) r_result <= w_mul_res;
        DIV: begin
          r_rem <= w_step_rem;
          r_a   <= {r_a[WIDTH-2:0], w_step_q};
          r_cnt <= r_cnt - CNT_W'(1);
        end
        FIX: if (!kill_i) r_result <= w_fix_res;
        default: ;
      endcase
    end
  end

  assign req_ready_o = (r_state == IDLE);
  assign rsp_valid_o = (r_state == DONE);
  assign busy_o      = (r_state != IDLE);
  assign result_o    = r_result;

endmodule

// File: tb/tb_mdu_iter.sv
// Directed self-checking bench for mdu_iter: multiply/divide results,
// latencies, divide special cases, backpressure, kill and async reset.
module tb_mdu_iter;
  import mdu_pkg::*;

  localparam int W = 32;

  logic         clk_i = 1'b0;
  logic         rst_ni;
  logic         req_valid_i;
  logic         req_ready_o;
  logic [2:0]   op_i;
  logic [W-1:0] a_i, b_i;
  logic         kill_i;
  logic         rsp_valid_o;
  logic         rsp_ready_i;
  logic [W-1:0] result_o;
  logic         busy_o;

  int checks   = 0;
  int failures = 0;

  always #5 clk_i = ~clk_i;

  mdu_iter #(.WIDTH(W)) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .req_valid_i(req_valid_i),
    .req_ready_o(req_ready_o),
    .op_i       (op_i),
    .a_i        (a_i),
    .b_i        (b_i),
    .kill_i     (kill_i),
    .rsp_valid_o(rsp_valid_o),
    .rsp_ready_i(rsp_ready_i),
    .result_o   (result_o),
    .busy_o     (busy_o)
  );

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
    end
  endtask

  // Issue one request with rsp_ready_i held high; check latency, result and return to idle.
  task automatic run(input string tag, input logic [2:0] op, input logic [W-1:0] a,
                     input logic [W-1:0] b, input logic [W-1:0] res, input int lat);
    int cyc;
    @(negedge clk_i);
    check({tag, "_ready"}, {31'b0, req_ready_o}, 32'd1);
    req_valid_i = 1'b1;
    op_i        = op;
    a_i         = a;
    b_i         = b;
    @(negedge clk_i);
    req_valid_i = 1'b0;
    cyc = 1;
    while (!rsp_valid_o && cyc < 100) begin
      @(negedge clk_i);
      cyc++;
    end
    check({tag, "_lat"}, W'(cyc), W'(lat));
    check({tag, "_res"}, result_o, res);
    @(negedge clk_i);
    check({tag, "_idle"}, {30'b0, req_ready_o, rsp_valid_o}, 32'b10);
  endtask

  initial begin
    int cyc;
    int seen;
    rst_ni      = 1'b0;
    req_valid_i = 1'b0;
    op_i        = 3'd0;
    a_i         = '0;
    b_i         = '0;
    kill_i      = 1'b0;
    rsp_ready_i = 1'b1;
    #1;
    check("reset_ctl", {29'b0, busy_o, rsp_valid_o, req_ready_o}, 32'b001);
    check("reset_res", result_o, 32'h0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    run("mulhu",  MDU_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 2);
    run("mul",    MDU_MUL,    32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 2);
    run("mulh",   MDU_MULH,   32'h80000000, 32'h80000000, 32'h40000000, 2);
    run("mulhsu", MDU_MULHSU, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 2);
    run("div",    MDU_DIV,    32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 34);
    run("rem",    MDU_REM,    32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 34);
    run("div_nb", MDU_DIV,    32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFD, 34);
    run("rem_nb", MDU_REM,    32'h00000007, 32'hFFFFFFFE, 32'h00000001, 34);
    run("divu",   MDU_DIVU,   32'd100,      32'd7,        32'd14,       34);
    run("remu",   MDU_REMU,   32'd100,      32'd7,        32'd2,        34);
    run("divu_big", MDU_DIVU, 32'hFFFFFFFF, 32'h00000010, 32'h0FFFFFFF, 34);
    run("divu_z", MDU_DIVU,   32'd5,        32'd0,        32'hFFFFFFFF, 1);
    run("rem_z",  MDU_REM,    32'd5,        32'd0,        32'd5,        1);
    run("div_ov", MDU_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
    run("rem_ov", MDU_REM,    32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1);

    // Backpressure: response held for 5 cycles with rsp_ready_i low.
    rsp_ready_i = 1'b0;
    @(negedge clk_i);
    req_valid_i = 1'b1;
    op_i        = MDU_MUL;
    a_i         = 32'd3;
    b_i         = 32'd5;
    @(negedge clk_i);
    req_valid_i = 1'b0;
    cyc = 1;
    while (!rsp_valid_o && cyc < 100) begin
      @(negedge clk_i);
      cyc++;
    end
    check("bp_lat", W'(cyc), 32'd2);
    for (int i = 0; i < 5; i++) begin
      check("bp_ctl", {29'b0, busy_o, rsp_valid_o, req_ready_o}, 32'b110);
      check("bp_res", result_o, 32'd15);
      @(negedge clk_i);
    end
    rsp_ready_i = 1'b1;
    @(negedge clk_i);
    check("bp_release", {30'b0, req_ready_o, rsp_valid_o}, 32'b10);

    // Kill during the divide loop.
    @(negedge clk_i);
    req_valid_i = 1'b1;
    op_i        = MDU_DIVU;
    a_i         = 32'd100;
    b_i         = 32'd7;
    @(negedge clk_i);
    req_valid_i = 1'b0;
    repeat (9) @(negedge clk_i);
    check("kill_pre", {29'b0, busy_o, rsp_valid_o, req_ready_o}, 32'b100);
    kill_i = 1'b1;
    @(negedge clk_i);
    kill_i = 1'b0;
    check("kill_idle", {29'b0, busy_o, rsp_valid_o, req_ready_o}, 32'b001);
    seen = 0;
    repeat (40) begin
      @(negedge clk_i);
      if (rsp_valid_o) seen++;
    end
    check("kill_norsp", W'(seen), 32'd0);
    check("kill_res_hold", result_o, 32'd15);

    // Asynchronous reset in the middle of a divide.
    @(negedge clk_i);
    req_valid_i = 1'b1;
    op_i        = MDU_DIV;
    a_i         = 32'hFFFFFFF9;
    b_i         = 32'd2;
    @(negedge clk_i);
    req_valid_i = 1'b0;
    repeat (5) @(negedge clk_i);
    check("rst_pre", {29'b0, busy_o, rsp_valid_o, req_ready_o}, 32'b100);
    #2 rst_ni = 1'b0;
    #1;
    check("rst_mid_ctl", {29'b0, busy_o, rsp_valid_o, req_ready_o}, 32'b001);
    check("rst_mid_res", result_o, 32'h0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    run("mul_after_rst", MDU_MUL, 32'd3, 32'd4, 32'd12, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
